// File: rtl/leg_solver_pkg.sv
// Shared types and helpers for the leg solver: FSM state encoding and counter sizing.
package leg_solver_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        SQ_H,
        SQ_L,
        SQRT,
        FIN,
        ERR
    } state_t;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/leg_solver_isqrt_seq.sv
// Restoring digit-by-digit square root of a 2W-bit radicand, one root bit per enabled cycle, MSB first.
module isqrt_seq
    import leg_solver_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           load,
    input  logic [2*W-1:0] radicand,
    output logic [W-1:0]   root,
    output logic [W:0]     rem,
    output logic           fin
);

    localparam int CW = clog2(W);

    logic [2*W-1:0] rad_sr;
    logic [W:0]     rem_r;
    logic [W-1:0]   root_r;
    logic [CW-1:0]  cnt;
    logic           running;
    logic [W+2:0]   rem_shift;
    logic [W+2:0]   trial;

    // Bring down the next radicand digit pair and test against 4*root+1.
    assign rem_shift = {rem_r, rad_sr[2*W-1 -: 2]};
    assign trial     = {1'b0, root_r, 2'b01};
    assign fin       = running && (cnt == CW'(W - 1));
    assign root      = root_r;
    assign rem       = rem_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_sr  <= '0;
            rem_r   <= '0;
            root_r  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (ena) begin
            if (load) begin
                rad_sr  <= radicand;
                rem_r   <= '0;
                root_r  <= '0;
                cnt     <= '0;
                running <= 1'b1;
            end else if (running) begin
                rad_sr <= {rad_sr[2*W-3:0], 2'b00};
                if (rem_shift >= trial) begin
                    rem_r  <= (W+1)'(rem_shift - trial);
                    root_r <= {root_r[W-2:0], 1'b1};
                end else begin
                    rem_r  <= (W+1)'(rem_shift);
                    root_r <= {root_r[W-2:0], 1'b0};
                end
                if (cnt == CW'(W - 1)) begin
                    running <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/leg_solver.sv
// Computes b = sqrt(c^2 - a^2) iteratively: shift-add squaring of both operands, then a sequential root.
// Define LEG_SOLVER_ROUND_EN for round-to-nearest results instead of floor.
module leg_solver
    import leg_solver_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         start,
    input  logic [W-1:0] hyp,
    input  logic [W-1:0] leg,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result
);

    localparam int CW = clog2(W);

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    hyp_r, leg_r;
    logic [2*W-1:0]  acc, hsq;
    logic [W-1:0]    op;
    logic [2*W-1:0]  addend, acc_sum, radicand;
    logic            cnt_last, accept, sq_load, sq_fin;
    logic [W-1:0]    sq_root, final_root;
    logic [W:0]      sq_rem;

    // A start coinciding with the done pulse is deliberately not accepted.
    assign accept   = (state == IDLE) && start && !done;
    assign cnt_last = (cnt == CW'(W - 1));
    assign op       = (state == SQ_H) ? hyp_r : leg_r;
    assign addend   = op[cnt] ? ({{W{1'b0}}, op} << cnt) : '0;
    assign acc_sum  = acc + addend;
    assign radicand = hsq - acc_sum;
    assign sq_load  = (state == SQ_L) && cnt_last && ena;

    isqrt_seq #(.W(W)) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .load     (sq_load),
        .radicand (radicand),
        .root     (sq_root),
        .rem      (sq_rem),
        .fin      (sq_fin)
    );

`ifdef LEG_SOLVER_ROUND_EN
    always_comb begin
        final_root = sq_root;
        if (({1'b0, sq_root} < sq_rem) && (sq_root != '1)) begin
            final_root = sq_root + 1'b1;
        end
    end
`else
    logic unused_rem;
    assign unused_rem = ^sq_rem;
    always_comb begin
        final_root = sq_root;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (leg > hyp) ? ERR : SQ_H;
            SQ_H: if (cnt_last) state_next = SQ_L;
            SQ_L: if (cnt_last) state_next = SQRT;
            SQRT: if (sq_fin) state_next = FIN;
            FIN:  state_next = IDLE;
            ERR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The accumulator is shared: it builds hyp^2 first, then leg^2 after a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            hyp_r  <= '0;
            leg_r  <= '0;
            acc    <= '0;
            hsq    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        hyp_r <= hyp;
                        leg_r <= leg;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                SQ_H: begin
                    if (cnt_last) begin
                        hsq <= acc_sum;
                        acc <= '0;
                        cnt <= '0;
                    end else begin
                        acc <= acc_sum;
                        cnt <= cnt + 1'b1;
                    end
                end
                SQ_L: begin
                    acc <= acc_sum;
                    cnt <= cnt_last ? '0 : cnt + 1'b1;
                end
                FIN: begin
                    result <= final_root;
                    err    <= 1'b0;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                ERR: begin
                    result <= '0;
                    err    <= 1'b1;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_leg_solver.sv
// Randomized self-checking bench for leg_solver against an arithmetic reference model.
module tb_leg_solver;

    localparam int W = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic [W-1:0] hyp;
    logic [W-1:0] leg;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;

    int vectors;
    int miscompares;

    leg_solver #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .start  (start),
        .hyp    (hyp),
        .leg    (leg),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: largest r with r*r <= c^2 - a^2, optionally rounded to nearest.
    function automatic void modelLeg(input int h, input int l, output bit e, output int r);
        int d;
        e = (l > h);
        r = 0;
        if (e) return;
        d = h * h - l * l;
        while ((r + 1) * (r + 1) <= d) r++;
`ifdef LEG_SOLVER_ROUND_EN
        if ((d - r * r > r) && (r < MAXV)) r++;
`endif
    endfunction

    task automatic applyStimulus(input int h, input int l, input int gap_at, input int gap_len,
                                 input bit extra_start, input int hold_len);
        bit exp_err;
        int exp_res;
        int exp_lat;
        int lat;
        bit busy_ok;
        bit hold_ok;
        modelLeg(h, l, exp_err, exp_res);
        exp_lat = exp_err ? 1 : (3 * W + 1 + ((gap_at > 0) ? gap_len : 0));
        @(negedge clk);
        hyp   = W'(h);
        leg   = W'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hyp   = W'($urandom);
        leg   = W'($urandom);
        checkOutput("busy_after_accept", busy, 1);
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            start = extra_start && (k == 5);
            ena   = !((gap_at > 0) && (k >= gap_at) && (k < gap_at + gap_len));
        end
        ena = 1'b1;
        checkOutput("latency", lat, exp_lat);
        checkOutput("busy_during_job", busy_ok, 1);
        checkOutput("result", result, exp_res);
        checkOutput("err", err, exp_err);
        checkOutput("busy_at_done", busy, 0);
        if (hold_len > 0) begin
            ena     = 1'b0;
            hold_ok = 1'b1;
            repeat (hold_len) begin
                @(negedge clk);
                if (!done) hold_ok = 1'b0;
            end
            ena = 1'b1;
            checkOutput("done_held_by_ena", hold_ok, 1);
        end
        start = extra_start;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_one_cycle", done, 0);
        checkOutput("busy_after_done", busy, 0);
        @(negedge clk);
        checkOutput("result_held", result, exp_res);
    endtask

    task automatic applyMidJobReset(input int h, input int l);
        bit seen_done;
        @(negedge clk);
        hyp   = W'(h);
        leg   = W'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_result", result, 0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        checkOutput("no_done_after_reset", seen_done, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        ena         = 1'b1;
        start       = 1'b0;
        hyp         = '0;
        leg         = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_result", result, 0);
        rst_n = 1'b1;

        applyStimulus(5, 3, 0, 0, 1'b0, 0);
        applyStimulus(255, 0, 0, 0, 1'b0, 0);
        applyStimulus(200, 200, 0, 0, 1'b0, 0);
        applyStimulus(10, 12, 0, 0, 1'b0, 0);
        applyStimulus(13, 12, 0, 0, 1'b0, 0);
        applyStimulus(10, 3, 0, 0, 1'b0, 0);
        applyStimulus(0, 0, 0, 0, 1'b0, 0);
        applyStimulus(255, 1, 0, 0, 1'b0, 0);

        applyStimulus(5, 3, 0, 0, 1'b1, 0);
        applyStimulus(200, 120, 18, 7, 1'b0, 0);
        applyStimulus(17, 8, 0, 0, 1'b0, 3);
        applyMidJobReset(100, 60);
        applyStimulus(13, 12, 0, 0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            int h;
            int l;
            int gap;
            h   = int'($urandom_range(0, MAXV));
            l   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXV)) : int'($urandom_range(0, h));
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 24)) : 0;
            applyStimulus(h, l, gap, int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
